// File: rtl/min_max_ctrl.sv
// min_max_ctrl: sequencing controller for the min/max LED bar datapath.
// Runs a lamp self-test after reset or on request, accepts display configs
// over valid/ready, and generates the blink signal.
// Optional build macro MIN_MAX_CTRL_CLAMP_EN clamps normal-mode values into [min,max].
module min_max_ctrl #(
    parameter int VALSIZE     = 4,
    parameter int OSC_DIV     = 8,
    parameter int TEST_CYCLES = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic [VALSIZE-1:0] cfg_min_i,
    input  logic [VALSIZE-1:0] cfg_max_i,
    input  logic [VALSIZE-1:0] cfg_value_i,
    input  logic               cfg_linear_i,
    input  logic               test_req_i,
    output logic [1:0]         com_o,
    output logic [VALSIZE-1:0] min_o,
    output logic [VALSIZE-1:0] max_o,
    output logic [VALSIZE-1:0] val_o,
    output logic               osc_o,
    output logic               busy_o,
    output logic               err_o
);
    localparam int PW = TEST_CYCLES > 1 ? $clog2(TEST_CYCLES) : 1;
    localparam int OW = OSC_DIV > 1 ? $clog2(OSC_DIV) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(TEST_CYCLES - 1);
    localparam logic [OW-1:0] OSC_LAST   = OW'(OSC_DIV - 1);
    localparam logic [1:0] T_OFF   = 2'd0;
    localparam logic [1:0] T_ON    = 2'd1;
    localparam logic [1:0] RUN     = 2'd2;
    localparam logic [1:0] COM_OFF = 2'b10;
    localparam logic [1:0] COM_ON  = 2'b11;

    logic [1:0]         state_q, state_d;
    logic [PW-1:0]      phase_q, phase_d;
    logic [OW-1:0]      osc_cnt_q, osc_cnt_d;
    logic               osc_q, osc_d;
    logic [VALSIZE-1:0] min_q, min_d, max_q, max_d, val_q, val_d;
    logic               mode_q, mode_d;
    logic [1:0]         com_q, com_d;
    logic               cfg_ready_q, cfg_ready_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               xfer, cfg_ok, accept;
    logic [VALSIZE-1:0] val_in;

    // Lamp-test sequencer: each test phase lasts TEST_CYCLES cycles, RUN exits on request.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q + 1'b1;
        if (state_q == RUN) begin
            phase_d = '0;
            state_d = test_req_i ? T_OFF : RUN;
        end else if (phase_q == PHASE_LAST) begin
            phase_d = '0;
            state_d = (state_q == T_OFF) ? T_ON : RUN;
        end
    end

    // Config intake: a transfer with min > max completes but only raises err.
    always_comb begin
        xfer   = cfg_valid_i & cfg_ready_q;
        cfg_ok = cfg_min_i <= cfg_max_i;
        accept = xfer & cfg_ok;
`ifdef MIN_MAX_CTRL_CLAMP_EN
        val_in = cfg_linear_i ? cfg_value_i :
                 (cfg_value_i < cfg_min_i) ? cfg_min_i :
                 (cfg_value_i > cfg_max_i) ? cfg_max_i : cfg_value_i;
`else
        val_in = cfg_value_i;
`endif
        min_d  = accept ? cfg_min_i : min_q;
        max_d  = accept ? cfg_max_i : max_q;
        val_d  = accept ? val_in : val_q;
        mode_d = accept ? cfg_linear_i : mode_q;
        err_d  = xfer & ~cfg_ok;
    end

    // Blink generator: free-running divider, phase restarts high on every accepted config.
    always_comb begin
        osc_cnt_d = (accept || osc_cnt_q == OSC_LAST) ? '0 : osc_cnt_q + 1'b1;
        osc_d     = accept ? 1'b1 : (osc_cnt_q == OSC_LAST) ? ~osc_q : osc_q;
    end

    // Status and command outputs follow the next state so they are registered yet in step.
    always_comb begin
        cfg_ready_d = state_d == RUN;
        busy_d      = ~cfg_ready_d;
        com_d       = (state_d == RUN) ? {1'b0, mode_d} : (state_d == T_ON) ? COM_ON : COM_OFF;
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= T_OFF;
            phase_q     <= '0;
            osc_cnt_q   <= '0;
            osc_q       <= 1'b0;
            min_q       <= '0;
            max_q       <= '1;
            val_q       <= '0;
            mode_q      <= 1'b0;
            com_q       <= COM_OFF;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            osc_cnt_q   <= osc_cnt_d;
            osc_q       <= osc_d;
            min_q       <= min_d;
            max_q       <= max_d;
            val_q       <= val_d;
            mode_q      <= mode_d;
            com_q       <= com_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign cfg_ready_o = cfg_ready_q;
    assign com_o       = com_q;
    assign min_o       = min_q;
    assign max_o       = max_q;
    assign val_o       = val_q;
    assign osc_o       = osc_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;
endmodule
